floor_req_encoder: RTL
======================

Name: floor_req_encoder

Overview:
- Converts the eight raw floor-call buttons into the 4-bit floor code used across the elevator controller: floor n is code n (1..8), bit n-1 in one-hot form, and 0 means no floor.
- Performs the reverse of the floor-code-to-one-hot decoder that drives the lamps.
- Synchronises and debounces the buttons, latches pending requests, and clears them when the car serves a floor.
- Selects the next target floor from the latched requests using direction-aware (SCAN) priority. The result feeds the car-motion FSM.

Parameters:
- DB_CYCLES, 4: consecutive cycles a synchronised button must hold its new level before the change is accepted. Legal range 1..255.
- NFLOORS, 8: number of floors. Fixed at 8; the parameter exists for documentation only.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn  in  8  raw call buttons; bit n-1 = floor n; asynchronous to clk
- cur_floor  in  4  current car floor code; valid values 1..8
- dir_up  in  1  current travel direction; 1 = up, 0 = down
- serve  in  1  single-cycle pulse: the car has served cur_floor
- req_pending  out  8  latched pending requests, one-hot per floor
- target_floor  out  4  selected next floor code; 0 when no request is pending
- target_valid  out  1  high when target_floor is non-zero

Behaviour:
- Reset: all outputs are 0, all synchroniser flops 0, all debounce counters 0, all debounced levels 0. Reset is asynchronous and takes effect immediately, including mid-debounce; pending requests are lost.
- Synchronisation: each btn bit passes through a 2-flop synchroniser.
- Debounce, per bit:
  - The counter resets to 0 whenever the synced value equals the debounced level.
  - Otherwise it increments each cycle.
  - When it reaches DB_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DB_CYCLES cycles has no effect.
- Press event: a 0->1 flip of the debounced level generates a one-cycle set pulse. A held button sets its request once only. Release needs no action except re-arming the edge detector.
- Latency, for btn rising before edge 1 and held:
  - synced high after edge 2;
  - debounced level flips at edge 2+DB_CYCLES;
  - req_pending bit sets at edge 3+DB_CYCLES;
  - target_floor/target_valid update at edge 4+DB_CYCLES.
- Clear: when serve=1 and cur_floor is 1..8, the matching req_pending bit clears on that edge. If serve=1 with cur_floor 0 or 9..15, nothing is cleared.
- Simultaneous set and clear on the same bit in the same cycle: clear wins, because the car is at that floor. Sets and clears on different bits both take effect.
- Target selection is combinational on the current req_pending, cur_floor and dir_up, and is registered into target_floor one cycle later.
  - dir_up=1: the lowest pending floor >= cur_floor. If there is none, the highest pending floor < cur_floor.
  - dir_up=0: the highest pending floor <= cur_floor. If there is none, the lowest pending floor > cur_floor.
  - cur_floor invalid (0 or >8): the lowest pending floor, regardless of direction.
  - No request pending: target_floor=0, target_valid=0.
- target_valid is always equal to (target_floor != 0); both come from the same register stage.
- Arithmetic: floor comparisons are unsigned 4-bit. Codes 9..15 are never produced on target_floor.

Decomposition:
- Shared package (elevator_pkg):
  - FLOOR_W=4 and NFLOORS=8;
  - FLOOR_NONE=4'd0;
  - floor-code <-> one-hot conversion functions, so that the decoder and this block share a single definition.
- Sub-module btn_debounce, instanced 8 times. It contains the 2-flop synchroniser, the DB_CYCLES counter, the debounced level and the rising-edge pulse. Ports: clk, rst, raw, level, rise.
- Top level holds the pending register, the clear logic and the SCAN priority encoder.

Test Plan:
- Reset then idle: assert rst mid-run with req_pending=8'h24 -> all outputs 0 immediately, before any clk edge; after release target_floor=0 and target_valid=0.
- Single press, DB_CYCLES=4: btn=8'h10 held from before edge 1 -> req_pending=8'h10 at edge 7; target_floor=5 and target_valid=1 at edge 8; holding the button 50 cycles causes no further change.
- Glitch reject: btn bit 2 high for 3 cycles then low -> req_pending stays 8'h00; high for 4 cycles -> bit 2 sets.
- SCAN selection with req_pending=8'b1000_0101 (floors 1, 3, 8) and cur_floor=4:
  - dir_up=1 -> target 8;
  - dir_up=0 -> target 3;
  - cur_floor=0 -> target 1.
- Serve clear: pending floors 3 and 8, cur_floor=3, dir_up=1, one-cycle serve -> req_pending=8'h80 the next edge, target_floor=8 one edge later; serve with cur_floor=3 and no bit 2 pending -> no change.
- Collision: the set pulse for floor 6 lands in the same cycle as serve with cur_floor=6 -> bit 5 remains 0; a set for floor 2 in that same cycle is still latched.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared floor-code definitions for the elevator controller.
// Floor n is code n (1..8) and bit n-1 in one-hot form; code 0 means no floor.
package elevator_pkg;

    localparam int FLOOR_W = 4;
    localparam int NFLOORS = 8;

    typedef logic [FLOOR_W-1:0] floor_t;
    typedef logic [NFLOORS-1:0] floor_oh_t;

    localparam floor_t FLOOR_NONE = floor_t'(0);

    // Invalid codes (0, 9..15) map to an all-zero vector.
    function automatic floor_oh_t floor_to_onehot(input floor_t code);
        floor_oh_t oh;
        oh = '0;
        for (int unsigned i = 0; i < NFLOORS; i++) begin
            if (code == floor_t'(i + 1)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // The lowest set bit wins when more than one bit is set.
    function automatic floor_t onehot_to_floor(input floor_oh_t oh);
        floor_t code;
        code = FLOOR_NONE;
        for (int unsigned i = 0; i < NFLOORS; i++) begin
            if (oh[NFLOORS-1-i]) begin
                code = floor_t'(NFLOORS - i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One call button: 2-flop synchroniser, hold-time debounce and a one-cycle
// press pulse on each accepted 0->1 change of the debounced level.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       level_q;
    logic       level_d;
    logic       rise_q;
    logic       rise_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            // DB_CYCLES-th consecutive differing sample: accept the change.
            cnt_d   = '0;
            level_d = ~level_q;
            rise_d  = ~level_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/floor_req_encoder.sv
// Debounces the floor-call buttons, latches pending requests, clears them when
// served, and picks the next target floor with direction-aware SCAN priority.
module floor_req_encoder #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned NFLOORS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn,
    input  logic [3:0] cur_floor,
    input  logic       dir_up,
    input  logic       serve,
    output logic [7:0] req_pending,
    output logic [3:0] target_floor,
    output logic       target_valid
);

    import elevator_pkg::*;

    logic [7:0] level;
    logic [7:0] rise;
    logic [7:0] set_bits;
    logic [7:0] clr_bits;
    logic [7:0] pend_q;
    logic [7:0] pend_d;
    floor_t     tgt_q;
    floor_t     tgt_d;
    logic       vld_q;
    logic       vld_d;
    logic       cur_valid;

    for (genvar g = 0; g < NFLOORS; g++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn[g]),
            .level(level[g]),
            .rise (rise[g])
        );
    end

    assign cur_valid = (cur_floor != FLOOR_NONE) && (cur_floor <= floor_t'(NFLOORS));
    assign set_bits  = rise & level;
    assign clr_bits  = serve ? floor_to_onehot(cur_floor) : '0;
    // Clear is applied after set so the served floor never re-latches.
    assign pend_d    = (pend_q | set_bits) & ~clr_bits;

    always_comb begin
        floor_t f;
        floor_t lo_ge;
        floor_t hi_lt;
        floor_t hi_le;
        floor_t lo_gt;
        f     = FLOOR_NONE;
        lo_ge = FLOOR_NONE;
        hi_lt = FLOOR_NONE;
        hi_le = FLOOR_NONE;
        lo_gt = FLOOR_NONE;
        tgt_d = FLOOR_NONE;
        for (int unsigned i = 0; i < NFLOORS; i++) begin
            f = floor_t'(i + 1);
            if (pend_q[i]) begin
                if ((f >= cur_floor) && (lo_ge == FLOOR_NONE)) lo_ge = f;
                if (f < cur_floor)                             hi_lt = f;
                if (f <= cur_floor)                            hi_le = f;
                if ((f > cur_floor) && (lo_gt == FLOOR_NONE))  lo_gt = f;
            end
        end
        if (!cur_valid) begin
            tgt_d = onehot_to_floor(pend_q);
        end else if (dir_up) begin
            tgt_d = (lo_ge != FLOOR_NONE) ? lo_ge : hi_lt;
        end else begin
            tgt_d = (hi_le != FLOOR_NONE) ? hi_le : lo_gt;
        end
        vld_d = (tgt_d != FLOOR_NONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            tgt_q  <= FLOOR_NONE;
            vld_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            tgt_q  <= tgt_d;
            vld_q  <= vld_d;
        end
    end

    assign req_pending  = pend_q;
    assign target_floor = tgt_q;
    assign target_valid = vld_q;

endmodule
